// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 polynomial, frame field encodings and header bit offsets.
package can_pkg;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int unsigned CRC_LEN    = 15;
    localparam logic [3:0]  CRC_LAST   = 4'(CRC_LEN - 1);

    // Header bit positions, counted from SOF = 0
    localparam logic [5:0] BASE_RTR_IDX = 6'd12;
    localparam logic [5:0] IDE_IDX      = 6'd13;
    localparam logic [5:0] BASE_DLC_IDX = 6'd15;
    localparam logic [5:0] EXT_RTR_IDX  = 6'd32;
    localparam logic [5:0] EXT_DLC_IDX  = 6'd35;
    localparam logic [5:0] DLC_SPAN     = 6'd3;

    typedef enum logic [2:0] {
        FieldIdle  = 3'd0,
        FieldHdr   = 3'd1,
        FieldData  = 3'd2,
        FieldCrc   = 3'd3,
        FieldDelim = 3'd4
    } field_e;

    function automatic logic [14:0] crc15_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
    endfunction

endpackage

// File: rtl/can_crc15_lfsr.sv
// CRC-15 LFSR with synchronous load, feedback shift, and a plain shift-out used to
// serialise the finished CRC MSB-first.
module can_crc15_lfsr
    import can_pkg::*;
#(
    parameter logic [14:0] INIT = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic        shift_out_i,
    input  logic        bit_i,
    output logic [14:0] crc_o
);

    logic [14:0] crc_q, crc_d, base;

    // Load and shift may coincide: the first bit of a frame is folded into the fresh value.
    always_comb begin
        base  = load_i ? INIT : crc_q;
        crc_d = base;
        if (shift_i) begin
            crc_d = crc15_step(base, bit_i);
        end else if (shift_out_i) begin
            crc_d = {base[13:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/can_crc_seq.sv
// Frame-aware CRC sequencer: tracks SOF..CRC delimiter on the destuffed bit stream,
// generates the CRC in TX and checks it in RX.
module can_crc_seq
    import can_pkg::*;
#(
    parameter int unsigned MAX_DLC_BYTES = 8,
    parameter logic [14:0] CRC_INIT      = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick_i,
    input  logic        frame_start_i,
    input  logic        bit_in_i,
    input  logic        tx_mode_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic [2:0]  field_o,
    output logic        crc_phase_o,
    output logic        tx_crc_bit_o,
    output logic [14:0] crc_value_o,
    output logic        done_o,
    output logic        crc_err_o,
    output logic        delim_err_o
);

    field_e      field_q, field_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic        ext_q, ext_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [6:0]  data_cnt_q, data_cnt_d;
    logic [3:0]  crc_cnt_q, crc_cnt_d;
    logic        mode_q, mode_d;
    logic        mismatch_q, mismatch_d;
    logic [14:0] crc_value_q, crc_value_d;
    logic        done_q, done_d;
    logic        crc_err_q, crc_err_d;
    logic        delim_err_q, delim_err_d;

    logic        lfsr_load, lfsr_shift, lfsr_shift_out;
    logic [14:0] lfsr_crc;
    logic [14:0] crc_next;
    logic [3:0]  dlc_full;
    logic [3:0]  dlc_bytes;
    logic [6:0]  nbits;
    logic        in_dlc, dlc_last;

    can_crc15_lfsr #(
        .INIT(CRC_INIT)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lfsr_load),
        .shift_i    (lfsr_shift),
        .shift_out_i(lfsr_shift_out),
        .bit_i      (bit_in_i),
        .crc_o      (lfsr_crc)
    );

    // crc_value must capture the LFSR including the bit shifted on this tick
    assign crc_next = crc15_step(lfsr_crc, bit_in_i);
    assign dlc_full = {dlc_q[2:0], bit_in_i};

    assign in_dlc = ext_q ? (bit_idx_q >= EXT_DLC_IDX && bit_idx_q <= EXT_DLC_IDX + DLC_SPAN)
                          : (bit_idx_q >= BASE_DLC_IDX && bit_idx_q <= BASE_DLC_IDX + DLC_SPAN);
    assign dlc_last = ext_q ? (bit_idx_q == EXT_DLC_IDX + DLC_SPAN)
                            : (bit_idx_q == BASE_DLC_IDX + DLC_SPAN);

    always_comb begin
        dlc_bytes = dlc_full;
        if ({28'd0, dlc_full} > MAX_DLC_BYTES) begin
            dlc_bytes = MAX_DLC_BYTES[3:0];
        end
        nbits = rtr_q ? 7'd0 : {dlc_bytes, 3'b000};
    end

    always_comb begin
        field_d        = field_q;
        bit_idx_d      = bit_idx_q;
        ext_d          = ext_q;
        rtr_d          = rtr_q;
        dlc_d          = dlc_q;
        data_cnt_d     = data_cnt_q;
        crc_cnt_d      = crc_cnt_q;
        mode_d         = mode_q;
        mismatch_d     = mismatch_q;
        crc_value_d    = crc_value_q;
        done_d         = 1'b0;
        crc_err_d      = 1'b0;
        delim_err_d    = 1'b0;
        lfsr_load      = 1'b0;
        lfsr_shift     = 1'b0;
        lfsr_shift_out = 1'b0;

        if (bit_tick_i && frame_start_i) begin
            lfsr_load  = 1'b1;
            lfsr_shift = 1'b1;
            field_d    = FieldHdr;
            bit_idx_d  = 6'd1;
            mode_d     = tx_mode_i;
            ext_d      = 1'b0;
            rtr_d      = 1'b0;
            dlc_d      = 4'd0;
            data_cnt_d = 7'd0;
            crc_cnt_d  = 4'd0;
            mismatch_d = 1'b0;
        end else if (abort_i) begin
            field_d = FieldIdle;
        end else if (bit_tick_i) begin
            case (field_q)
                FieldHdr: begin
                    lfsr_shift = 1'b1;
                    bit_idx_d  = bit_idx_q + 6'd1;
                    if (bit_idx_q == IDE_IDX) begin
                        ext_d = bit_in_i;
                    end
                    // Base RTR slot is SRR in extended frames; the later RTR overwrites it
                    if (bit_idx_q == BASE_RTR_IDX || (ext_q && bit_idx_q == EXT_RTR_IDX)) begin
                        rtr_d = bit_in_i;
                    end
                    if (in_dlc) begin
                        dlc_d = dlc_full;
                    end
                    if (dlc_last) begin
                        if (nbits == 7'd0) begin
                            field_d     = FieldCrc;
                            crc_value_d = crc_next;
                            crc_cnt_d   = 4'd0;
                        end else begin
                            field_d    = FieldData;
                            data_cnt_d = nbits;
                        end
                    end
                end
                FieldData: begin
                    lfsr_shift = 1'b1;
                    data_cnt_d = data_cnt_q - 7'd1;
                    if (data_cnt_q == 7'd1) begin
                        field_d     = FieldCrc;
                        crc_value_d = crc_next;
                        crc_cnt_d   = 4'd0;
                    end
                end
                FieldCrc: begin
                    lfsr_shift_out = 1'b1;
                    if (!mode_q && (bit_in_i != lfsr_crc[14])) begin
                        mismatch_d = 1'b1;
                    end
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == CRC_LAST) begin
                        field_d = FieldDelim;
                    end
                end
                FieldDelim: begin
                    done_d      = 1'b1;
                    delim_err_d = !bit_in_i;
                    crc_err_d   = !mode_q && mismatch_q;
                    field_d     = FieldIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q     <= FieldIdle;
            bit_idx_q   <= 6'd0;
            ext_q       <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= 4'd0;
            data_cnt_q  <= 7'd0;
            crc_cnt_q   <= 4'd0;
            mode_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            crc_value_q <= 15'h0000;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            delim_err_q <= 1'b0;
        end else begin
            field_q     <= field_d;
            bit_idx_q   <= bit_idx_d;
            ext_q       <= ext_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            data_cnt_q  <= data_cnt_d;
            crc_cnt_q   <= crc_cnt_d;
            mode_q      <= mode_d;
            mismatch_q  <= mismatch_d;
            crc_value_q <= crc_value_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            delim_err_q <= delim_err_d;
        end
    end

    assign busy_o       = (field_q != FieldIdle);
    assign field_o      = field_q;
    assign crc_phase_o  = (field_q == FieldCrc);
    assign tx_crc_bit_o = (field_q == FieldCrc) && mode_q && lfsr_crc[14];
    assign crc_value_o  = crc_value_q;
    assign done_o       = done_q;
    assign crc_err_o    = crc_err_q;
    assign delim_err_o  = delim_err_q;

endmodule

// File: doc/can_crc_seq.md
Name: can_crc_seq

Overview:
Frame-aware CRC sequencer for the CAN 2.0B bit engine. It consumes the destuffed bit stream one bit per bit_tick and tracks frame fields from SOF through the CRC delimiter. It owns a CRC-15 LFSR (polynomial 0x4599, init 0) and clears it per frame, feeding it only SOF..end-of-data. TX mode serialises the CRC MSB-first; RX mode checks the received CRC and delimiter and flags errors.

Parameters:
MAX_DLC_BYTES, 8, data-byte clamp applied to DLC values 9..15
CRC_INIT, 15'h0000, LFSR value loaded on frame_start

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
bit_tick  in  1  one-cycle strobe per sample point; all state advances only on ticks
frame_start  in  1  tick-qualified: the current bit_in is SOF
bit_in  in  1  destuffed bit (TX: bit being sent; RX: bit received)
tx_mode  in  1  1=TX (generate CRC), 0=RX (check CRC); sampled at frame_start
abort  in  1  arbitration lost / error frame; return to IDLE
busy  out  1  frame in progress
field  out  3  0 IDLE, 1 HDR, 2 DATA, 3 CRC, 4 DELIM
crc_phase  out  1  high while the CRC field is active
tx_crc_bit  out  1  CRC bit to transmit, valid while crc_phase and tx_mode
crc_value  out  15  LFSR value frozen at end of data
done  out  1  one-cycle pulse on the delimiter tick
crc_err  out  1  RX only, one-cycle pulse with done on CRC mismatch
delim_err  out  1  one-cycle pulse with done if the delimiter bit is 0 (both modes)

Behaviour:
- Reset: all outputs 0, field=IDLE, LFSR=CRC_INIT, bit counter 0.
- frame_start&bit_tick: LFSR loaded to CRC_INIT, then SOF bit shifted in the same tick. bit_idx=1, field=HDR, busy=1, mode latched. frame_start has priority over abort and restarts from any state.
- abort (without frame_start): next cycle field=IDLE, busy=0. No done/err pulses.
- HDR: every tick shifts bit_in into the LFSR and increments bit_idx.
  - bit_idx 13 (IDE) sets ext.
  - Base frame: RTR at idx 12, DLC at idx 15..18.
  - Extended frame: RTR at idx 32, DLC at idx 35..38.
  - On the last DLC bit: nbits = 0 if RTR=1, else 8*min(DLC,MAX_DLC_BYTES). Go to DATA if nbits>0, else CRC.
- DATA: shift into the LFSR and decrement the data counter. On the last data bit, go to CRC.
- Entering CRC: crc_value latches the LFSR. During CRC the LFSR shifts left with zero fill (no feedback), so tx_crc_bit=lfsr[14]. The first CRC bit is available the cycle after the last covered tick and is held until the next tick.
- RX CRC: each tick compares bit_in with lfsr[14] before the shift; any mismatch sets a sticky mismatch flag.
- CRC lasts 15 ticks, then DELIM.
- DELIM tick:
  - done=1.
  - delim_err=!bit_in.
  - crc_err = RX & mismatch.
  - Next cycle field=IDLE, busy=0.
- LFSR update: fb=bit_in^c[14]; c<= {c[13:0],0} ^ (fb ? 15'h4599 : 0).
- Ticks in IDLE without frame_start are ignored. Nothing advances between ticks.
- Pulses are registered, exactly one clk wide.

Decomposition:
- Shared package can_pkg: CRC15_POLY=15'h4599, field encodings, header bit offsets (IDE_IDX=13, BASE_DLC_IDX=15, EXT_DLC_IDX=35), CRC_LEN=15.
- One sub-module: can_crc15_lfsr (15-bit LFSR with sync load, enable, and a shift-out mode without feedback).
- FSM and counters stay in can_crc_seq.

Test Plan:
- TX base frame, all 19 bits 0 (ID 0, RTR 0, DLC 0) -> DATA skipped; crc_value=0x0000; 15 tx_crc_bit zeros; done on tick 35, no errors.
- Base frame, SOF=1, all other header bits 0, delimiter 1 -> after the first tick the LFSR reads 0x4599; crc_value matches the golden model; RX loopback of the TX CRC bits gives done with crc_err=0.
- Extended frame with RTR=1, DLC=4 -> no DATA; crc_phase rises after idx 38. Base frame with DLC=15 -> 64 data bits; crc_phase rises after idx 82.
- RX frame with one flipped CRC bit -> crc_err=1 and done on the delimiter tick. Same frame with delimiter 0 -> delim_err=1.
- abort mid-DATA -> busy=0 next cycle, no done. frame_start on the same tick as abort -> restart, field=HDR.
- rst asserted mid-CRC -> all outputs 0 immediately. Ticks after release are ignored until frame_start.
